// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ctrl_pkg
// Description : Shared definitions for the SPI master frame sequencer.
//               FSM state encodings and named logic levels.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SETUP = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_div
// Description : SCLK generator. Counts CLK_DIV system clocks per SCLK
//               half-period while enabled, toggles SCLK on the terminal
//               count and flags whether that toggle is a leading edge
//               (leaving the idle level) or a trailing edge.
// Ports       : clk, clr          - clock, synchronous active-high reset
//               en                - run the divider (held at zero otherwise)
//               sclk              - serial clock, idles at CPOL
//               tick              - this cycle ends a half-period (SCLK toggles)
//               lead / trail      - tick qualified by edge direction
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div
  import spi_ctrl_pkg::*;
#(
  parameter int   CLK_DIV = 4,
  parameter logic CPOL    = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic sclk,
  output logic tick,
  output logic lead,
  output logic trail
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick  = en & (div_cnt == DIV_LAST);
  // SCLK still sits at its pre-toggle level during the tick cycle.
  assign lead  = tick & (sclk == CPOL);
  assign trail = tick & (sclk != CPOL);

  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt <= '0;
      sclk    <= CPOL;
    end else if (!en) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_sequencer
// Description : Frame sequencer for the SPI master datapath. Starts a frame
//               when transmit is enabled and a word is waiting, drives CS_N
//               and SCLK, and strobes the shift-register / buffer controls.
//               Optional macro SPI_BURST_EN: chain back-to-back frames with
//               CS_N held low when another word is ready at end of HOLD.
// Ports       : clk, clr                 - clock, synchronous active-high reset
//               te, re                   - transmit / receive enable
//               tx_valid, rx_full        - sender word ready, receiver occupied
//               ovr_clr                  - clears overrun
//               tx_load, shift_out,
//               sample, rx_store, done   - single-cycle strobes
//               sclk, cs_n               - SPI bus clock and chip select
//               busy, overrun            - status (overrun is sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_sequencer
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0
) (
  input  logic clk,
  input  logic clr,
  input  logic te,
  input  logic re,
  input  logic tx_valid,
  input  logic rx_full,
  input  logic ovr_clr,
  output logic tx_load,
  output logic shift_out,
  output logic sample,
  output logic rx_store,
  output logic sclk,
  output logic cs_n,
  output logic busy,
  output logic done,
  output logic overrun
);

  localparam int WAIT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);
  localparam logic [EDGE_W-1:0] EDGE_ZERO = '0;
  localparam logic SCLK_IDLE = (CPOL != 0) ? HIGH : LOW;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;   // SETUP / HOLD dwell counter
  logic [EDGE_W-1:0] edge_cnt;   // SCLK edge index within the frame
  logic              in_shift;
  logic              tick;
  logic              lead;
  logic              trail;
  logic              last_wait;
  logic              hold_end;
  logic              frame_start;
  logic              burst_go;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (SCLK_IDLE)
  ) u_clk_div (
    .clk   (clk),
    .clr   (clr),
    .en    (in_shift),
    .sclk  (sclk),
    .tick  (tick),
    .lead  (lead),
    .trail (trail)
  );

  assign in_shift    = (state == ST_SHIFT);
  assign last_wait   = (wait_cnt == WAIT_LAST);
  assign hold_end    = (state == ST_HOLD) & last_wait;
  assign frame_start = (state == ST_IDLE) & te & tx_valid;

`ifdef SPI_BURST_EN
  assign burst_go = hold_end & te & tx_valid;
`else
  assign burst_go = LOW;
`endif

  assign tx_load  = frame_start | burst_go;
  assign done     = hold_end;
  assign rx_store = hold_end & re & ~rx_full;
  assign busy     = (state != ST_IDLE);

  // Bit 0 is presented by TX_LOAD itself, so the data-change edge that would
  // present it again is suppressed: the last trailing edge for CPHA=0, the
  // first leading edge for CPHA=1.
  generate
    if (CPHA == 0) begin : g_cpha0
      assign sample    = in_shift & lead;
      assign shift_out = in_shift & trail & (edge_cnt != EDGE_LAST);
    end else begin : g_cpha1
      assign sample    = in_shift & trail;
      assign shift_out = in_shift & lead & (edge_cnt != EDGE_ZERO);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_IDLE;
      cs_n     <= HIGH;
      overrun  <= LOW;
      wait_cnt <= '0;
      edge_cnt <= '0;
    end else begin
      // A coincident clear loses to a new overrun.
      if (hold_end & re & rx_full) begin
        overrun <= HIGH;
      end else if (ovr_clr) begin
        overrun <= LOW;
      end

      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state    <= ST_SETUP;
            cs_n     <= LOW;
            wait_cnt <= '0;
          end
        end
        ST_SETUP: begin
          if (last_wait) begin
            state    <= ST_SHIFT;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (edge_cnt == EDGE_LAST) begin
              edge_cnt <= '0;
              state    <= ST_HOLD;
            end else begin
              edge_cnt <= edge_cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (last_wait) begin
            wait_cnt <= '0;
            if (burst_go) begin
              state <= ST_SHIFT;
            end else begin
              state <= ST_IDLE;
              cs_n  <= HIGH;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cs_n  <= HIGH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_xfer_sequencer
// Description : Self-checking bench. Two sequencers share one stimulus:
//               u0 (CPOL=0, CPHA=0) and u1 (CPOL=1, CPHA=1). Expected pulse
//               events are queued when a frame is launched and popped as the
//               sequencers emit them. Honours SPI_BURST_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_sequencer;

  localparam int DW  = 8;
  localparam int DIV = 4;
  localparam int BIG = 1 << 30;
  // Event kinds, also their in-cycle ordering.
  localparam int K_LOAD = 0, K_SHIFT = 1, K_SAMPLE = 2, K_STORE = 3, K_DONE = 4;

  logic clk = 1'b0;
  logic clr, te, re, tx_valid, rx_full, ovr_clr;
  logic tx_load0, shift_out0, sample0, rx_store0, sclk0, cs_n0, busy0, done0, overrun0;
  logic tx_load1, shift_out1, sample1, rx_store1, sclk1, cs_n1, busy1, done1, overrun1;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int exp_q[$];   // keys: cycle*16 + dut*8 + kind, kept sorted

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_xfer_sequencer #(.DATA_WIDTH(DW), .CLK_DIV(DIV), .CPOL(0), .CPHA(0)) u0 (
    .clk(clk), .clr(clr), .te(te), .re(re), .tx_valid(tx_valid), .rx_full(rx_full),
    .ovr_clr(ovr_clr), .tx_load(tx_load0), .shift_out(shift_out0), .sample(sample0),
    .rx_store(rx_store0), .sclk(sclk0), .cs_n(cs_n0), .busy(busy0), .done(done0),
    .overrun(overrun0));

  spi_xfer_sequencer #(.DATA_WIDTH(DW), .CLK_DIV(DIV), .CPOL(1), .CPHA(1)) u1 (
    .clk(clk), .clr(clr), .te(te), .re(re), .tx_valid(tx_valid), .rx_full(rx_full),
    .ovr_clr(ovr_clr), .tx_load(tx_load1), .shift_out(shift_out1), .sample(sample1),
    .rx_store(rx_store1), .sclk(sclk1), .cs_n(cs_n1), .busy(busy1), .done(done1),
    .overrun(overrun1));

  task automatic check(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_ev(int c, int d, int k, int limit);
    int key;
    int i;
    if (c < limit) begin
      key = c * 16 + d * 8 + k;
      i = 0;
      while (i < exp_q.size() && exp_q[i] <= key) i++;
      exp_q.insert(i, key);
    end
  endtask

  // Frame launched by TX_LOAD at t0; 'setup' is the CS setup length before
  // the first SCLK half-period (0 for a burst continuation).
  task automatic push_frame(int t0, int setup, bit store, int limit);
    int c;
    bit leading;
    for (int d = 0; d < 2; d++) begin
      push_ev(t0, d, K_LOAD, limit);
      for (int k = 0; k < 2 * DW; k++) begin
        c = t0 + setup + DIV * (k + 1);
        leading = (k % 2) == 0;
        if ((d == 0) ? leading : !leading)
          push_ev(c, d, K_SAMPLE, limit);
        else if (!((d == 0 && k == 2 * DW - 1) || (d == 1 && k == 0)))
          push_ev(c, d, K_SHIFT, limit);
      end
      c = t0 + setup + DIV * (2 * DW + 1);
      if (store) push_ev(c, d, K_STORE, limit);
      push_ev(c, d, K_DONE, limit);
    end
  endtask

  task automatic obs_pulses(int d, logic tl, logic so, logic sa, logic rs, logic dn, logic sc);
    logic [4:0] v;
    int exp;
    v = {dn, rs, sa, so, tl};
    for (int k = 0; k < 5; k++) begin
      if (v[k]) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check($sformatf("pulse u%0d kind%0d cyc%0d", d, k, cyc), cyc * 16 + d * 8 + k, exp);
      end
    end
    // SCLK is low just before a rising toggle.
    if (sa) check($sformatf("u%0d sample on rising sclk", d), int'(sc), 0);
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      obs_pulses(0, tx_load0, shift_out0, sample0, rx_store0, done0, sclk0);
      obs_pulses(1, tx_load1, shift_out1, sample1, rx_store1, done1, sclk1);
    end
  end

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_at(int c);
    while (cyc < c) at_pos();
  endtask

  task automatic go_neg(int c);
    do @(negedge clk); while (cyc < c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    clr = 1'b1; te = 1'b0; re = 1'b0; tx_valid = 1'b0; rx_full = 1'b0; ovr_clr = 1'b0;
    repeat (3) at_pos();
    clr = 1'b0;

    // Reset state
    go_neg(cyc);
    check("reset cs_n", int'(cs_n0), 1);
    check("reset sclk u0", int'(sclk0), 0);
    check("reset sclk u1", int'(sclk1), 1);
    check("reset busy", int'(busy0), 0);
    check("reset overrun", int'(overrun0), 0);

    // Basic frame, TX_VALID pulse
    drive_at(cyc + 2);
    t0 = cyc; te = 1'b1; re = 1'b1; tx_valid = 1'b1;
    push_frame(t0, DIV, 1'b1, BIG);
    at_pos(); tx_valid = 1'b0;
    go_neg(t0 + 1);
    check("f1 cs_n low", int'(cs_n0), 0);
    check("f1 busy", int'(busy0), 1);
    check("f1 u1 sclk idle", int'(sclk1), 1);
    go_neg(t0 + 9);
    check("f1 sclk rose", int'(sclk0), 1);
    go_neg(t0 + 72);
    check("f1 cs_n last", int'(cs_n0), 0);
    go_neg(t0 + 73);
    check("f1 cs_n high", int'(cs_n0), 1);
    check("f1 u1 cs_n high", int'(cs_n1), 1);
    check("f1 busy low", int'(busy0), 0);
    check("f1 u1 sclk back", int'(sclk1), 1);

    // Overrun: set, clear, and set winning over a coincident clear
    drive_at(cyc + 3);
    t0 = cyc; tx_valid = 1'b1; rx_full = 1'b1;
    push_frame(t0, DIV, 1'b0, BIG);
    at_pos(); tx_valid = 1'b0;
    go_neg(t0 + 72);
    check("ovr before", int'(overrun0), 0);
    go_neg(t0 + 73);
    check("ovr set u0", int'(overrun0), 1);
    check("ovr set u1", int'(overrun1), 1);
    drive_at(t0 + 75); ovr_clr = 1'b1;
    at_pos(); ovr_clr = 1'b0;
    go_neg(t0 + 76);
    check("ovr cleared", int'(overrun0), 0);
    drive_at(t0 + 78);
    t0 = cyc; tx_valid = 1'b1;
    push_frame(t0, DIV, 1'b0, BIG);
    at_pos(); tx_valid = 1'b0;
    drive_at(t0 + 72); ovr_clr = 1'b1;
    at_pos(); ovr_clr = 1'b0;
    go_neg(t0 + 73);
    check("ovr set wins", int'(overrun0), 1);
    drive_at(t0 + 75); ovr_clr = 1'b1; rx_full = 1'b0;
    at_pos(); ovr_clr = 1'b0;
    go_neg(t0 + 76);
    check("ovr cleared 2", int'(overrun0), 0);

    // Reset mid-frame
    drive_at(cyc + 3);
    t0 = cyc; tx_valid = 1'b1;
    push_frame(t0, DIV, 1'b1, t0 + 30);
    at_pos(); tx_valid = 1'b0;
    drive_at(t0 + 30); clr = 1'b1;
    at_pos(); clr = 1'b0;
    go_neg(t0 + 31);
    check("clr cs_n", int'(cs_n0), 1);
    check("clr sclk u0", int'(sclk0), 0);
    check("clr sclk u1", int'(sclk1), 1);
    check("clr busy", int'(busy0), 0);
    drive_at(t0 + 40);
    t0 = cyc; tx_valid = 1'b1;
    push_frame(t0, DIV, 1'b1, BIG);
    at_pos(); tx_valid = 1'b0;
    go_neg(t0 + 73);
    check("restart cs_n high", int'(cs_n0), 1);

    // TE dropped mid-frame, TX_VALID held
    drive_at(cyc + 3);
    t0 = cyc; tx_valid = 1'b1;
    push_frame(t0, DIV, 1'b1, BIG);
    drive_at(t0 + 20); te = 1'b0;
    go_neg(t0 + 100);
    check("te drop idle", int'(busy0), 0);
    check("te drop cs_n", int'(cs_n0), 1);
    drive_at(cyc + 1); tx_valid = 1'b0;

    // Two words with TX_VALID held
    drive_at(cyc + 2);
    t0 = cyc; te = 1'b1; tx_valid = 1'b1;
    push_frame(t0, DIV, 1'b1, BIG);
`ifdef SPI_BURST_EN
    push_frame(t0 + 72, 0, 1'b1, BIG);
`else
    push_frame(t0 + 73, DIV, 1'b1, BIG);
`endif
    go_neg(t0 + 72);
    check("pair cs_n end f1", int'(cs_n0), 0);
    go_neg(t0 + 73);
`ifdef SPI_BURST_EN
    check("pair cs_n held", int'(cs_n0), 0);
`else
    check("pair cs_n gap", int'(cs_n0), 1);
`endif
    drive_at(t0 + 74); tx_valid = 1'b0;
    go_neg(t0 + 150);
    check("pair end idle", int'(busy0), 0);
    check("pair end cs_n", int'(cs_n0), 1);

    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
